// File: rtl/trace_buffer.sv
// Debug write-back trace capture FIFO with end-of-test marker detection.
// Records every non-r0 register write until the marker is seen, then drains over valid/ready.
module trace_buffer #(
   parameter int          DEPTH     = 16,
   parameter logic [31:0] END_MAGIC = 32'habcd0000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     debug_reg_write_en,
   input  logic [4:0]               debug_reg_write_addr,
   input  logic [31:0]              debug_reg_write_data,
   input  logic [31:0]              debug_pc_addr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc,
   output logic [4:0]               out_addr,
   output logic [31:0]              out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [15:0]              drop_count,
   output logic                     done,
   output logic                     finished
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   logic [68:0]    mem_q [DEPTH];
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           overflow_q, overflow_d;
   logic           done_q, done_d;
   logic [15:0]    drop_q, drop_d;
   logic           cap, pop, push, drop;

   always_comb begin
      cap  = debug_reg_write_en && (debug_reg_write_addr != 5'd0) && !done_q;
      pop  = (count_q != '0) && out_ready;
      // A full FIFO still takes the new entry when the head leaves in the same cycle.
      push = cap && ((count_q != FULL_C) || pop);
      drop = cap && !push;

      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      drop_d     = drop_q;
      done_d     = done_q;

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (drop) begin
         overflow_d = 1'b1;
         if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end

      // The marker ends capture even when its own entry had to be dropped.
      if (cap && (debug_reg_write_data == END_MAGIC)) done_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
         done_q     <= done_d;
      end
   end

   // Storage is deliberately left uncleared by reset.
   always_ff @(posedge clk) begin
      if (push && !rst) mem_q[wr_ptr_q] <= {debug_pc_addr, debug_reg_write_addr, debug_reg_write_data};
   end

   assign {out_pc, out_addr, out_data} = mem_q[rd_ptr_q];
   assign out_valid  = (count_q != '0);
   assign count      = count_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_q;
   assign done       = done_q;
   assign finished   = done_q && (count_q == '0);
endmodule

// File: tb/tb_trace_buffer.sv
// Self-checking bench for trace_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_trace_buffer;
   localparam int          DEPTH = 16;
   localparam logic [31:0] MAGIC = 32'habcd0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] wpc = '0;
   logic        ready = 1'b0;

   logic        out_valid;
   logic [31:0] out_pc;
   logic [4:0]  out_addr;
   logic [31:0] out_data;
   logic [4:0]  count;
   logic        overflow;
   logic [15:0] drop_count;
   logic        done;
   logic        finished;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [68:0] m_q[$];
   bit          m_ovf;
   bit          m_done;
   int          m_drops;

   trace_buffer #(.DEPTH(DEPTH), .END_MAGIC(MAGIC)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .debug_reg_write_en   (en),
      .debug_reg_write_addr (waddr),
      .debug_reg_write_data (wdata),
      .debug_pc_addr        (wpc),
      .out_valid            (out_valid),
      .out_ready            (ready),
      .out_pc               (out_pc),
      .out_addr             (out_addr),
      .out_data             (out_data),
      .count                (count),
      .overflow             (overflow),
      .drop_count           (drop_count),
      .done                 (done),
      .finished             (finished)
   );

   always #5 clk = ~clk;

   task automatic model_clear();
      m_q.delete();
      m_ovf   = 0;
      m_done  = 0;
      m_drops = 0;
   endtask

   // Applies the capture/push/pop/drop rules to the inputs present this cycle.
   task automatic model_step();
      bit cap, pop, push;
      cap  = en && (waddr != 5'd0) && !m_done;
      pop  = ready && (m_q.size() != 0);
      push = cap && ((m_q.size() < DEPTH) || pop);
      if (pop) begin
         $display("pop  pc=%h addr=%0d data=%h", m_q[0][68:37], m_q[0][36:32], m_q[0][31:0]);
         void'(m_q.pop_front());
      end
      if (push) m_q.push_back({wpc, waddr, wdata});
      if (cap && !push) begin
         m_ovf = 1;
         if (m_drops < 65535) m_drops++;
      end
      if (cap && wdata == MAGIC) m_done = 1;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; en = 1'b0; ready = 1'b0;
      model_clear();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic capture(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
      en = 1'b1; waddr = a; wdata = d; wpc = p;
      cycle();
      en = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      n_checks++; if (count !== 5'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else n_pass++;
      n_checks++; if (drop_count !== 16'd0) $display("FAIL reset_drops got=%0d exp=0", drop_count); else n_pass++;
      n_checks++; if (done !== 1'b0 || finished !== 1'b0)
         $display("FAIL reset_done got=%b/%b exp=0/0", done, finished); else n_pass++;
      model_clear();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single_write();
      apply_reset();
      capture(5'd5, 32'h1234, 32'h10);
      n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", out_valid); else n_pass++;
      n_checks++; if ({out_pc, out_addr, out_data} !== {32'h10, 5'd5, 32'h1234})
         $display("FAIL single_entry got=%h/%0d/%h exp=10/5/1234", out_pc, out_addr, out_data); else n_pass++;
      n_checks++; if (count !== 5'd1) $display("FAIL single_count got=%0d exp=1", count); else n_pass++;
      ready = 1'b1;
      cycle();
      ready = 1'b0;
      n_checks++; if (out_valid !== 1'b0 || count !== 5'd0)
         $display("FAIL single_drain got valid=%b count=%0d exp 0/0", out_valid, count); else n_pass++;
   endtask

   task automatic test_r0_filter();
      apply_reset();
      capture(5'd0, 32'hFFFF_FFFF, 32'h20);
      n_checks++; if (count !== 5'd0) $display("FAIL r0_count got=%0d exp=0", count); else n_pass++;
      en = 1'b0; waddr = 5'd3; wdata = 32'h33; wpc = 32'h24;
      cycle();
      n_checks++; if (count !== 5'd0) $display("FAIL en0_count got=%0d exp=0", count); else n_pass++;
   endtask

   task automatic test_overflow();
      apply_reset();
      for (int i = 0; i < 20; i++) capture(5'(1 + i % 31), i, 32'(i * 4));
      n_checks++; if (count !== 5'd16) $display("FAIL ovf_count got=%0d exp=16", count); else n_pass++;
      n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", overflow); else n_pass++;
      n_checks++; if (drop_count !== 16'd4) $display("FAIL ovf_drops got=%0d exp=4", drop_count); else n_pass++;
      ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         n_checks++; if (out_valid !== 1'b1 || out_data !== 32'(i))
            $display("FAIL ovf_drain%0d got valid=%b data=%h exp 1/%h", i, out_valid, out_data, i); else n_pass++;
         cycle();
      end
      ready = 1'b0;
      n_checks++; if (count !== 5'd0) $display("FAIL ovf_empty got=%0d exp=0", count); else n_pass++;
   endtask

   task automatic test_full_push_pop();
      apply_reset();
      for (int i = 0; i < 16; i++) capture(5'd7, 32'(100 + i), 32'h100);
      n_checks++; if (count !== 5'd16) $display("FAIL full_count got=%0d exp=16", count); else n_pass++;
      ready = 1'b1;
      capture(5'd8, 32'hAA, 32'h200);
      ready = 1'b0;
      n_checks++; if (count !== 5'd16 || drop_count !== 16'd0)
         $display("FAIL full_pushpop got count=%0d drops=%0d exp 16/0", count, drop_count); else n_pass++;
      ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         n_checks++; if (out_data !== ((i == 15) ? 32'hAA : 32'(101 + i)))
            $display("FAIL full_drain%0d got=%h", i, out_data); else n_pass++;
         cycle();
      end
      ready = 1'b0;
   endtask

   task automatic test_end_marker();
      logic [31:0] exp_seq [3];
      int n_seen = 0;
      exp_seq[0] = 32'd1; exp_seq[1] = 32'd2; exp_seq[2] = MAGIC;
      apply_reset();
      ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         en = (i < 4); waddr = 5'd9; wpc = 32'(i);
         wdata = (i == 0) ? 32'd1 : (i == 1) ? 32'd2 : (i == 2) ? MAGIC : 32'd7;
         if (out_valid === 1'b1) begin
            n_checks++; if (n_seen > 2 || out_data !== exp_seq[n_seen > 2 ? 2 : n_seen])
               $display("FAIL marker_drain%0d got=%h", n_seen, out_data); else n_pass++;
            n_seen++;
         end
         cycle();
         if (i == 2) begin
            n_checks++; if (done !== 1'b1 || finished !== 1'b0)
               $display("FAIL marker_done got done=%b fin=%b exp 1/0", done, finished); else n_pass++;
         end
         if (i == 3) begin
            n_checks++; if (finished !== 1'b1 || count !== 5'd0)
               $display("FAIL marker_finished got fin=%b count=%0d exp 1/0", finished, count); else n_pass++;
         end
      end
      en = 1'b0; ready = 1'b0;
      n_checks++; if (n_seen !== 3) $display("FAIL marker_entries got=%0d exp=3", n_seen); else n_pass++;
   endtask

   task automatic test_reset_mid_drain();
      apply_reset();
      for (int i = 0; i < 17; i++) capture(5'd4, 32'(i), 32'h40);
      ready = 1'b1;
      for (int i = 0; i < 11; i++) cycle();
      ready = 1'b0;
      n_checks++; if (count !== 5'd5 || overflow !== 1'b1)
         $display("FAIL mid_setup got count=%0d ovf=%b exp 5/1", count, overflow); else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_checks++; if (count !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || done !== 1'b0)
         $display("FAIL mid_async got count=%0d valid=%b ovf=%b done=%b exp all 0", count, out_valid, overflow, done);
      else n_pass++;
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      capture(5'd6, 32'h55, 32'h60);
      n_checks++; if (count !== 5'd1 || out_valid !== 1'b1 || out_data !== 32'h55)
         $display("FAIL mid_after got count=%0d valid=%b data=%h exp 1/1/55", count, out_valid, out_data); else n_pass++;
   endtask

   task automatic test_random();
      logic [68:0] prev_out;
      logic        prev_hold;
      apply_reset();
      prev_hold = 1'b0;
      prev_out  = '0;
      for (int i = 0; i < 600; i++) begin
         n_checks++; if (count !== 5'(m_q.size()) || out_valid !== (m_q.size() != 0))
            $display("FAIL rnd_count c%0d got=%0d/%b exp=%0d", i, count, out_valid, m_q.size()); else n_pass++;
         n_checks++; if (overflow !== m_ovf || drop_count !== 16'(m_drops) || done !== m_done ||
                         finished !== (m_done && m_q.size() == 0))
            $display("FAIL rnd_flags c%0d got ovf=%b drops=%0d done=%b fin=%b exp %b/%0d/%b", i,
                     overflow, drop_count, done, finished, m_ovf, m_drops, m_done); else n_pass++;
         if (m_q.size() != 0) begin
            n_checks++; if ({out_pc, out_addr, out_data} !== m_q[0])
               $display("FAIL rnd_head c%0d got=%h exp=%h", i, {out_pc, out_addr, out_data}, m_q[0]); else n_pass++;
         end
         if (prev_hold) begin
            n_checks++; if ({out_pc, out_addr, out_data} !== prev_out)
               $display("FAIL rnd_stable c%0d got=%h exp=%h", i, {out_pc, out_addr, out_data}, prev_out); else n_pass++;
         end
         en    = ($urandom_range(0, 9) < 7);
         waddr = 5'($urandom_range(0, 31));
         wdata = $urandom;
         if (wdata == MAGIC) wdata = 32'h1;
         wpc   = $urandom;
         ready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) < 6);
         if (i == 450) begin en = 1'b1; waddr = 5'd1; wdata = MAGIC; end
         prev_hold = out_valid && !ready;
         prev_out  = {out_pc, out_addr, out_data};
         cycle();
      end
      en = 1'b0; ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_r0_filter();
      test_overflow();
      test_full_push_pop();
      test_end_marker();
      test_reset_mid_drain();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
